// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: pipelined opcode control unit.
// The D-stage opcode is decoded here, and its control bits travel through
// E, M and W pipeline registers. The unit also raises a load-use stall and a
// taken-branch flush, and counts cycles with either one asserted. Both
// counters saturate at their maximum value.
//
// Handshake: the D-stage instruction is valid only while i_valid=1. When
// o_stall=1 the instruction is not accepted: the fetch/D latch must present
// it again next cycle, and a bubble enters E. When o_flush=1 the D-stage
// instruction is squashed and never reaches E, and fetch is redirected.
// o_flush wins over o_stall. M and W advance every cycle and never stall.
module ctrl_pipe_unit #(
    parameter int OPW   = 4,
    parameter int ALUFW = 2,
    parameter int RW    = 3,
    parameter int CW    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [OPW-1:0]   i_opcode,
    input  logic [RW-1:0]    i_rd,
    input  logic [RW-1:0]    i_rs1,
    input  logic [RW-1:0]    i_rs2,
    input  logic             i_branch_taken,
    output logic             o_stall,
    output logic             o_flush,
    output logic [ALUFW-1:0] o_alufuncE,
    output logic             o_immE,
    output logic             o_branchE,
    output logic             o_illegalE,
    output logic             o_memwriteM,
    output logic             o_memtoregM,
    output logic             o_regwriteW,
    output logic             o_memtoregW,
    output logic [RW-1:0]    o_rdW,
    output logic [CW-1:0]    o_stall_cnt,
    output logic [CW-1:0]    o_flush_cnt
);

    // Highest legal opcode (JMP). Any larger value, including one with
    // nonzero bits above bit 3, is illegal.
    localparam logic [OPW-1:0] OP_LAST = OPW'(9);
    localparam logic [CW-1:0]  CNT_MAX = {CW{1'b1}};

    // E-stage contents. The jmp bit records that E holds a JMP, so a
    // redirect does not need the full opcode in E.
    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic             imm;
        logic             branch;
        logic             jmp;
        logic             illegal;
        logic [ALUFW-1:0] alufunc;
        logic [RW-1:0]    rd;
    } e_stage_t;

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic          memwrite;
        logic [RW-1:0] rd;
    } m_stage_t;

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic [RW-1:0] rd;
    } w_stage_t;

    e_stage_t dec;
    e_stage_t e_d;
    e_stage_t e_q;
    m_stage_t m_q;
    w_stage_t w_q;

    logic          stall;
    logic          flush;
    logic          hazard_src;
    logic [CW-1:0] stall_cnt_q;
    logic [CW-1:0] flush_cnt_q;

    // Decode the D-stage opcode into E-stage control bits.
    always_comb begin
        dec    = '0;
        dec.rd = i_rd;
        if (i_opcode > OP_LAST) begin
            dec.illegal = 1'b1;
        end else begin
            case (i_opcode[3:0])
                4'd0: dec.illegal = 1'b0;
                4'd1: dec.regwrite = 1'b1;
                4'd2: begin
                    dec.regwrite = 1'b1;
                    dec.alufunc  = ALUFW'(2'b01);
                end
                4'd3: begin
                    dec.regwrite = 1'b1;
                    dec.alufunc  = ALUFW'(2'b10);
                end
                4'd4: begin
                    dec.regwrite = 1'b1;
                    dec.alufunc  = ALUFW'(2'b11);
                end
                4'd5: begin
                    dec.regwrite = 1'b1;
                    dec.imm      = 1'b1;
                end
                4'd6: begin
                    dec.regwrite = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.imm      = 1'b1;
                end
                4'd7: begin
                    dec.memwrite = 1'b1;
                    dec.imm      = 1'b1;
                end
                4'd8: begin
                    dec.branch  = 1'b1;
                    dec.alufunc = ALUFW'(2'b01);
                end
                4'd9: begin
                    dec.branch = 1'b1;
                    dec.jmp    = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
        end
    end

    // Hazard detection: a redirect from E, or a load in E whose result a
    // valid D instruction reads. A load to r0 never stalls.
    always_comb begin
        flush      = e_q.branch & (i_branch_taken | e_q.jmp);
        hazard_src = (e_q.rd == i_rs1) | (e_q.rd == i_rs2);
        stall      = i_valid & e_q.memtoreg & (e_q.rd != '0) & hazard_src & ~flush;
    end

    // Select what enters E next: a bubble on flush, stall or an empty D slot.
    always_comb begin
        e_d = dec;
        if (flush || stall || !i_valid) begin
            e_d = '0;
        end
    end

    // E/M/W pipeline registers. All three advance every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            e_q          <= e_d;
            m_q.regwrite <= e_q.regwrite;
            m_q.memtoreg <= e_q.memtoreg;
            m_q.memwrite <= e_q.memwrite;
            m_q.rd       <= e_q.rd;
            w_q.regwrite <= m_q.regwrite;
            w_q.memtoreg <= m_q.memtoreg;
            w_q.rd       <= m_q.rd;
        end
    end

    // Saturating counters of stall and flush cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CW'(1);
            end
            if (flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CW'(1);
            end
        end
    end

    // Drive the output ports from the stage registers.
    always_comb begin
        o_stall     = stall;
        o_flush     = flush;
        o_alufuncE  = e_q.alufunc;
        o_immE      = e_q.imm;
        o_branchE   = e_q.branch;
        o_illegalE  = e_q.illegal;
        o_memwriteM = m_q.memwrite;
        o_memtoregM = m_q.memtoreg;
        o_regwriteW = w_q.regwrite;
        o_memtoregW = w_q.memtoreg;
        o_rdW       = w_q.rd;
        o_stall_cnt = stall_cnt_q;
        o_flush_cnt = flush_cnt_q;
    end

endmodule
